// File: rtl/inst_encoder_pkg.sv
// Shared encoding constants for the instruction encoder: operand types, ALU codes,
// RV32IM opcodes/funct values, instruction formats and the buffered word type.
package inst_encoder_pkg;

  localparam logic [1:0] OP_TYPE_NONE = 2'd0;
  localparam logic [1:0] OP_TYPE_REG  = 2'd1;
  localparam logic [1:0] OP_TYPE_IMM  = 2'd2;
  localparam logic [1:0] OP_TYPE_PC   = 2'd3;

  localparam logic [5:0] ALU_LUI    = 6'd0;
  localparam logic [5:0] ALU_JAL    = 6'd1;
  localparam logic [5:0] ALU_JALR   = 6'd2;
  localparam logic [5:0] ALU_BEQ    = 6'd3;
  localparam logic [5:0] ALU_BNE    = 6'd4;
  localparam logic [5:0] ALU_BLT    = 6'd5;
  localparam logic [5:0] ALU_BGE    = 6'd6;
  localparam logic [5:0] ALU_BLTU   = 6'd7;
  localparam logic [5:0] ALU_BGEU   = 6'd8;
  localparam logic [5:0] ALU_LB     = 6'd9;
  localparam logic [5:0] ALU_LH     = 6'd10;
  localparam logic [5:0] ALU_LW     = 6'd11;
  localparam logic [5:0] ALU_LBU    = 6'd12;
  localparam logic [5:0] ALU_LHU    = 6'd13;
  localparam logic [5:0] ALU_SB     = 6'd14;
  localparam logic [5:0] ALU_SH     = 6'd15;
  localparam logic [5:0] ALU_SW     = 6'd16;
  localparam logic [5:0] ALU_ADD    = 6'd17;
  localparam logic [5:0] ALU_SUB    = 6'd18;
  localparam logic [5:0] ALU_SLT    = 6'd19;
  localparam logic [5:0] ALU_SLTU   = 6'd20;
  localparam logic [5:0] ALU_XOR    = 6'd21;
  localparam logic [5:0] ALU_OR     = 6'd22;
  localparam logic [5:0] ALU_AND    = 6'd23;
  localparam logic [5:0] ALU_SLL    = 6'd24;
  localparam logic [5:0] ALU_SRL    = 6'd25;
  localparam logic [5:0] ALU_SRA    = 6'd26;
  localparam logic [5:0] ALU_MUL    = 6'd27;
  localparam logic [5:0] ALU_MULH   = 6'd28;
  localparam logic [5:0] ALU_MULHSU = 6'd29;
  localparam logic [5:0] ALU_MULHU  = 6'd30;
  localparam logic [5:0] ALU_DIV    = 6'd31;
  localparam logic [5:0] ALU_DIVU   = 6'd32;
  localparam logic [5:0] ALU_REM    = 6'd33;
  localparam logic [5:0] ALU_REMU   = 6'd34;
  localparam logic [5:0] ALU_NOP    = 6'd63;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  typedef struct packed {
    logic [31:0] word;
    logic        illegal;
  } enc_word_t;

  function automatic logic [2:0] funct3_of(input logic [5:0] alu);
    case (alu)
      ALU_SLL,  ALU_MULH,   ALU_LH,  ALU_SH,  ALU_BNE:  return 3'b001;
      ALU_SLT,  ALU_MULHSU, ALU_LW,  ALU_SW:            return 3'b010;
      ALU_SLTU, ALU_MULHU:                              return 3'b011;
      ALU_XOR,  ALU_DIV,    ALU_LBU, ALU_BLT:           return 3'b100;
      ALU_SRL,  ALU_SRA,    ALU_DIVU, ALU_LHU, ALU_BGE: return 3'b101;
      ALU_OR,   ALU_REM,    ALU_BLTU:                   return 3'b110;
      ALU_AND,  ALU_REMU,   ALU_BGEU:                   return 3'b111;
      default:                                          return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-stream input and machine-word output handshakes of the instruction encoder.
interface inst_encoder_if #(parameter int ADDR_W = 16);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_alucode;
  logic [1:0]        in_op1_type;
  logic [1:0]        in_op2_type;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [4:0]        in_rd;
  logic [31:0]       in_imm;
  logic              in_halt;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;
  logic              out_illegal;
  logic              err_sticky;

  modport master (
    output in_valid, in_alucode, in_op1_type, in_op2_type, in_rs1, in_rs2, in_rd,
           in_imm, in_halt, out_ready,
    input  in_ready, out_valid, out_word, out_addr, out_illegal, err_sticky
  );

  modport slave (
    input  in_valid, in_alucode, in_op1_type, in_op2_type, in_rs1, in_rs2, in_rd,
           in_imm, in_halt, out_ready,
    output in_ready, out_valid, out_word, out_addr, out_illegal, err_sticky
  );
endinterface

// File: rtl/inst_encoder_pack.sv
// Combinational field-to-word packer: picks opcode/format from the ALU code and operand
// types, checks the immediate fits the format, and substitutes word 0 for halt/illegal.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  logic [5:0]  i_alucode,
  input  logic [1:0]  i_op1_type,
  input  logic [1:0]  i_op2_type,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_imm,
  input  logic        i_halt,
  output enc_word_t   o_enc
);

  fmt_e        w_fmt;
  logic [6:0]  w_opcode;
  logic [6:0]  w_f7;
  logic [2:0]  w_f3;
  logic        w_unmapped;
  logic        w_imm_ok;
  logic        w_bad;
  logic [31:0] w_word;
  logic        w_arith, w_muldiv, w_shift, w_load, w_store, w_branch;
  logic        w_src_rr, w_src_ri, w_src_ipc;

  assign w_f3      = funct3_of(i_alucode);
  assign w_arith   = (i_alucode >= ALU_ADD) && (i_alucode <= ALU_SRA);
  assign w_muldiv  = (i_alucode >= ALU_MUL) && (i_alucode <= ALU_REMU);
  assign w_shift   = (i_alucode >= ALU_SLL) && (i_alucode <= ALU_SRA);
  assign w_load    = (i_alucode >= ALU_LB)  && (i_alucode <= ALU_LHU);
  assign w_store   = (i_alucode >= ALU_SB)  && (i_alucode <= ALU_SW);
  assign w_branch  = (i_alucode >= ALU_BEQ) && (i_alucode <= ALU_BGEU);
  assign w_src_rr  = (i_op1_type == OP_TYPE_REG) && (i_op2_type == OP_TYPE_REG);
  assign w_src_ri  = (i_op1_type == OP_TYPE_REG) && (i_op2_type == OP_TYPE_IMM);
  assign w_src_ipc = (i_op1_type == OP_TYPE_IMM) && (i_op2_type == OP_TYPE_PC);

  // NOTE: every signal gets a default first so no path through the decode infers a latch.
  always_comb begin
    w_fmt      = FMT_R;
    w_opcode   = 7'b0;
    w_f7       = F7_ZERO;
    w_unmapped = 1'b0;
    if (w_arith) begin
      w_f7 = ((i_alucode == ALU_SUB) || (i_alucode == ALU_SRA)) ? F7_ALT : F7_ZERO;
      if (w_src_rr) begin
        w_opcode = OPC_OP;
      end else if (w_src_ri && (i_alucode != ALU_SUB)) begin
        w_fmt    = w_shift ? FMT_SH : FMT_I;
        w_opcode = OPC_OPIMM;
      end else if (w_src_ipc && (i_alucode == ALU_ADD)) begin
        w_fmt    = FMT_U;
        w_opcode = OPC_AUIPC;
      end else begin
        w_unmapped = 1'b1;
      end
    end else if (w_muldiv) begin
      w_f7       = F7_MULDIV;
      w_opcode   = OPC_OP;
      w_unmapped = !w_src_rr;
    end else if (w_load) begin
      w_fmt    = FMT_I;
      w_opcode = OPC_LOAD;
    end else if (w_store) begin
      w_fmt    = FMT_S;
      w_opcode = OPC_STORE;
    end else if (w_branch) begin
      w_fmt    = FMT_B;
      w_opcode = OPC_BRANCH;
    end else if (i_alucode == ALU_LUI) begin
      w_fmt    = FMT_U;
      w_opcode = OPC_LUI;
    end else if (i_alucode == ALU_JAL) begin
      w_fmt    = FMT_J;
      w_opcode = OPC_JAL;
    end else if (i_alucode == ALU_JALR) begin
      w_fmt    = FMT_I;
      w_opcode = OPC_JALR;
    end else begin
      w_unmapped = 1'b1;
    end
  end

  // Each format accepts only immediates its bit layout can reproduce exactly.
  always_comb begin
    case (w_fmt)
      FMT_I, FMT_S: w_imm_ok = (&i_imm[31:11]) || !(|i_imm[31:11]);
      FMT_SH:       w_imm_ok = !(|i_imm[31:5]);
      FMT_B:        w_imm_ok = ((&i_imm[31:12]) || !(|i_imm[31:12])) && !i_imm[0];
      FMT_J:        w_imm_ok = ((&i_imm[31:20]) || !(|i_imm[31:20])) && !i_imm[0];
      FMT_U:        w_imm_ok = !(|i_imm[11:0]);
      default:      w_imm_ok = 1'b1;
    endcase
  end

  always_comb begin
    case (w_fmt)
      FMT_I:   w_word = {i_imm[11:0], i_rs1, w_f3, i_rd, w_opcode};
      FMT_SH:  w_word = {w_f7, i_imm[4:0], i_rs1, w_f3, i_rd, w_opcode};
      FMT_S:   w_word = {i_imm[11:5], i_rs2, i_rs1, w_f3, i_imm[4:0], w_opcode};
      FMT_B:   w_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, w_f3, i_imm[4:1], i_imm[11],
                         w_opcode};
      FMT_U:   w_word = {i_imm[31:12], i_rd, w_opcode};
      FMT_J:   w_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, w_opcode};
      default: w_word = {w_f7, i_rs2, i_rs1, w_f3, i_rd, w_opcode};
    endcase
  end

  assign w_bad         = w_unmapped || !w_imm_ok;
  assign o_enc.word    = (i_halt || w_bad) ? 32'h0000_0000 : w_word;
  assign o_enc.illegal = !i_halt && w_bad;

endmodule

// File: rtl/inst_encoder.sv
// RV32IM instruction encoder: packs one field set per accepted transfer into a machine
// word, queues it in a 2-entry FIFO and tags each emitted word with its byte address.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0
) (
  input logic          clk,
  input logic          rst_n,
  inst_encoder_if.slave bus
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  enc_word_t         w_enc;
  enc_word_t         r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic [1:0]        w_count_nxt;
  logic              r_in_ready;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic              w_push;
  logic              w_pop;

  inst_pack u_pack (
    .i_alucode  (bus.in_alucode),
    .i_op1_type (bus.in_op1_type),
    .i_op2_type (bus.in_op2_type),
    .i_rs1      (bus.in_rs1),
    .i_rs2      (bus.in_rs2),
    .i_rd       (bus.in_rd),
    .i_imm      (bus.in_imm),
    .i_halt     (bus.in_halt),
    .o_enc      (w_enc)
  );

  assign w_push      = bus.in_valid && r_in_ready;
  assign w_pop       = (r_count != 2'd0) && bus.out_ready;
  assign w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two buffer entries are reset because the head drives out_word, which must read 0 after reset.
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
      r_addr     <= BASE;
      r_err      <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_enc;
        r_wr_ptr        <= !r_wr_ptr;
        if (w_enc.illegal) r_err <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= !r_rd_ptr;
        r_addr   <= r_addr + ADDR_W'(4);
      end
      r_count    <= w_count_nxt;
      // Ready is precomputed from the next occupancy, so out_ready never reaches in_ready combinationally.
      r_in_ready <= (w_count_nxt != 2'd2);
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = (r_count != 2'd0);
  assign bus.out_word    = r_mem[r_rd_ptr].word;
  assign bus.out_illegal = r_mem[r_rd_ptr].illegal;
  assign bus.out_addr    = r_addr;
  assign bus.err_sticky  = r_err;

endmodule
